// File: rtl/pc_ir_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_ir_unit
// Description : Program-control register block downstream of the CPU
//               controller FSM. Holds the program counter (PC), instruction
//               register (IR) and data address register (DAR), selects the
//               RAM address and decodes the IR into FSM/datapath fields.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               load_pc, pc_sel       - PC write enable, one-hot PC source
//               addr_sel              - 1: mem_addr=PC, 0: mem_addr=DAR
//               load_ir, load_addr    - IR / DAR write enables
//               nsel                  - one-hot register-number select
//               mem_data              - RAM read data (IR source)
//               datapath_out          - datapath result (PC / DAR source)
//               mem_addr, pc, ir      - RAM address, current PC and IR
//               opcode, op, cond      - decoded fields back to the FSM
//               readnum, writenum     - selected register number
//               shift, alu_op         - datapath control fields
//               sximm5, sximm8        - sign-extended immediates
//               pc_err                - sticky illegal pc_sel flag
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ir_unit #(
  parameter int PC_W = 9,
  parameter int IR_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_pc,
  input  logic [3:0]      pc_sel,
  input  logic            addr_sel,
  input  logic            load_ir,
  input  logic            load_addr,
  input  logic [2:0]      nsel,
  input  logic [IR_W-1:0] mem_data,
  input  logic [IR_W-1:0] datapath_out,
  output logic [PC_W-1:0] mem_addr,
  output logic [PC_W-1:0] pc,
  output logic [IR_W-1:0] ir,
  output logic [2:0]      opcode,
  output logic [1:0]      op,
  output logic [2:0]      cond,
  output logic [2:0]      readnum,
  output logic [2:0]      writenum,
  output logic [1:0]      shift,
  output logic [1:0]      alu_op,
  output logic [IR_W-1:0] sximm5,
  output logic [IR_W-1:0] sximm8,
  output logic            pc_err
);

  localparam logic [2:0] c_OPC_LDR = 3'b011;
  localparam logic [2:0] c_OPC_STR = 3'b100;

  logic [PC_W-1:0] r_pc;
  logic [IR_W-1:0] r_ir;
  logic [PC_W-1:0] r_dar;
  logic            r_pc_err;

  logic [PC_W-1:0] w_pc_next;
  logic            w_pc_sel_bad;
  logic [IR_W-1:0] w_sximm8;

  // Upper datapath bits never address the 512-word RAM.
  logic w_unused_dp;
  assign w_unused_dp = &{1'b0, datapath_out[IR_W-1:PC_W]};

  assign w_sximm8 = {{(IR_W-8){r_ir[7]}}, r_ir[7:0]};

  // Next PC from pre-edge PC and IR; anything other than exactly one-hot is
  // flagged and leaves the PC unchanged.
  always_comb begin
    w_pc_next    = r_pc;
    w_pc_sel_bad = 1'b0;
    case (pc_sel)
      4'b1000: w_pc_next = '0;
      4'b0100: w_pc_next = datapath_out[PC_W-1:0];
      4'b0010: w_pc_next = r_pc + w_sximm8[PC_W-1:0];
      4'b0001: w_pc_next = r_pc + PC_W'(1);
      default: w_pc_sel_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_dar    <= '0;
      r_pc_err <= 1'b0;
    end else begin
      if (load_pc) begin
        r_pc <= w_pc_next;
        if (w_pc_sel_bad) begin
          r_pc_err <= 1'b1;
        end
      end
      if (load_ir) begin
        r_ir <= mem_data;
      end
      if (load_addr) begin
        r_dar <= datapath_out[PC_W-1:0];
      end
    end
  end

  assign mem_addr = addr_sel ? r_pc : r_dar;
  assign pc       = r_pc;
  assign ir       = r_ir;
  assign pc_err   = r_pc_err;

  // Instruction decode
  assign opcode = r_ir[15:13];
  assign op     = r_ir[12:11];
  assign cond   = r_ir[10:8];
  assign alu_op = r_ir[12:11];
  assign sximm5 = {{(IR_W-5){r_ir[4]}}, r_ir[4:0]};
  assign sximm8 = w_sximm8;

  always_comb begin
    readnum = 3'b000;
    case (nsel)
      3'b100:  readnum = r_ir[10:8];
      3'b010:  readnum = r_ir[7:5];
      3'b001:  readnum = r_ir[2:0];
      default: readnum = 3'b000;
    endcase
  end

  assign writenum = readnum;

  // LDR/STR reuse ir[4:3] as part of imm5, so no shift is applied for them.
  assign shift = ((opcode == c_OPC_LDR) || (opcode == c_OPC_STR)) ? 2'b00 : r_ir[4:3];

endmodule
`default_nettype wire

// File: tb/tb_pc_ir_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ir_unit
// Description : Directed self-checking bench for pc_ir_unit. Expected values
//               are queued when stimulus is applied and compared when the
//               outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ir_unit;

  logic        clk;
  logic        reset;
  logic        load_pc;
  logic [3:0]  pc_sel;
  logic        addr_sel;
  logic        load_ir;
  logic        load_addr;
  logic [2:0]  nsel;
  logic [15:0] mem_data;
  logic [15:0] datapath_out;
  logic [8:0]  mem_addr;
  logic [8:0]  pc;
  logic [15:0] ir;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  cond;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shift;
  logic [1:0]  alu_op;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic        pc_err;

  pc_ir_unit #(.PC_W(9), .IR_W(16)) dut (
    .clk(clk), .reset(reset), .load_pc(load_pc), .pc_sel(pc_sel),
    .addr_sel(addr_sel), .load_ir(load_ir), .load_addr(load_addr),
    .nsel(nsel), .mem_data(mem_data), .datapath_out(datapath_out),
    .mem_addr(mem_addr), .pc(pc), .ir(ir), .opcode(opcode), .op(op),
    .cond(cond), .readnum(readnum), .writenum(writenum), .shift(shift),
    .alu_op(alu_op), .sximm5(sximm5), .sximm8(sximm8), .pc_err(pc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_PC = 0, S_IR = 1, S_ERR = 2, S_MA = 3, S_RN = 4, S_WN = 5,
                 S_SH = 6, S_ALU = 7, S_X5 = 8, S_X8 = 9, S_OPC = 10,
                 S_OP = 11, S_COND = 12;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [15:0] observe(int sig);
    case (sig)
      S_PC:    return {7'b0, pc};
      S_IR:    return ir;
      S_ERR:   return {15'b0, pc_err};
      S_MA:    return {7'b0, mem_addr};
      S_RN:    return {13'b0, readnum};
      S_WN:    return {13'b0, writenum};
      S_SH:    return {14'b0, shift};
      S_ALU:   return {14'b0, alu_op};
      S_X5:    return sximm5;
      S_X8:    return sximm8;
      S_OPC:   return {13'b0, opcode};
      S_OP:    return {14'b0, op};
      S_COND:  return {13'b0, cond};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [15:0] e);
    exp_t x;
    x.tag = tag;
    x.sig = sig;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_all();
    exp_t x;
    logic [15:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = observe(x.sig);
      vectors++;
      assert (o === x.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; load_pc = 1'b0; load_ir = 1'b0; load_addr = 1'b0;
    pc_sel = 4'b0000;
  endtask

  initial begin
    // Reset overrides every strobe
    reset = 1'b1; load_pc = 1'b1; pc_sel = 4'b0001; load_ir = 1'b1;
    mem_data = 16'hFFFF; load_addr = 1'b1; datapath_out = 16'hFFFF;
    addr_sel = 1'b1; nsel = 3'b000;
    tick();
    idle();
    expect_val("rst_pc", S_PC, 16'h0000);
    expect_val("rst_ir", S_IR, 16'h0000);
    expect_val("rst_err", S_ERR, 16'h0000);
    expect_val("rst_maddr_pc", S_MA, 16'h0000);
    check_all();
    addr_sel = 1'b0;
    settle();
    expect_val("rst_maddr_dar", S_MA, 16'h0000);
    check_all();

    // PC=511 then +1 wraps to 0
    load_pc = 1'b1; pc_sel = 4'b0100; datapath_out = 16'h01FF; addr_sel = 1'b1;
    tick();
    expect_val("pc_dp_load", S_PC, 16'h01FF);
    expect_val("maddr_pc", S_MA, 16'h01FF);
    check_all();
    pc_sel = 4'b0001;
    tick();
    expect_val("pc_inc_wrap", S_PC, 16'h0000);
    check_all();

    // IR=20FD (imm8=-3), PC=2, then PC+sximm8 wraps to 511
    load_ir = 1'b1; mem_data = 16'h20FD; pc_sel = 4'b0100; datapath_out = 16'h0002;
    tick();
    expect_val("ir_load_b", S_IR, 16'h20FD);
    expect_val("pc_2", S_PC, 16'h0002);
    expect_val("sximm8_neg", S_X8, 16'hFFFD);
    expect_val("opcode_b", S_OPC, 16'h0001);
    check_all();
    load_ir = 1'b0; pc_sel = 4'b0010;
    tick();
    expect_val("pc_branch_wrap", S_PC, 16'h01FF);
    check_all();

    // Same-edge IR load and branch uses the old imm8
    load_ir = 1'b1; mem_data = 16'h2001; pc_sel = 4'b0100; datapath_out = 16'h000A;
    tick();
    mem_data = 16'h2005; pc_sel = 4'b0010;
    tick();
    expect_val("pc_old_imm8", S_PC, 16'h000B);
    expect_val("ir_new", S_IR, 16'h2005);
    expect_val("sximm8_pos", S_X8, 16'h0005);
    check_all();

    // DAR load; illegal pc_sel with load_pc=0 is ignored
    idle();
    load_addr = 1'b1; datapath_out = 16'h0123; addr_sel = 1'b0; pc_sel = 4'b0110;
    tick();
    expect_val("maddr_dar", S_MA, 16'h0123);
    expect_val("err_ignored", S_ERR, 16'h0000);
    expect_val("pc_hold", S_PC, 16'h000B);
    check_all();
    load_addr = 1'b0; datapath_out = 16'h0000; addr_sel = 1'b1;
    settle();
    expect_val("maddr_sel_pc", S_MA, 16'h000B);
    check_all();
    addr_sel = 1'b0;
    tick();
    expect_val("dar_retained", S_MA, 16'h0123);
    check_all();

    // Decode of LDR 6A3F
    load_ir = 1'b1; mem_data = 16'h6A3F; nsel = 3'b100;
    tick();
    load_ir = 1'b0;
    expect_val("rn_rd", S_RN, 16'h0002);
    expect_val("rn_wr", S_WN, 16'h0002);
    expect_val("ldr_shift", S_SH, 16'h0000);
    expect_val("ldr_sx5", S_X5, 16'hFFFF);
    expect_val("ldr_opc", S_OPC, 16'h0003);
    expect_val("ldr_op", S_OP, 16'h0001);
    expect_val("ldr_cond", S_COND, 16'h0002);
    check_all();
    nsel = 3'b010; settle();
    expect_val("rd_sel", S_RN, 16'h0001);
    check_all();
    nsel = 3'b001; settle();
    expect_val("rm_sel", S_RN, 16'h0007);
    expect_val("rm_wr", S_WN, 16'h0007);
    check_all();
    nsel = 3'b011; settle();
    expect_val("nsel_multi", S_RN, 16'h0000);
    check_all();
    nsel = 3'b000; settle();
    expect_val("nsel_zero", S_WN, 16'h0000);
    check_all();

    // ALU ADD with shift, then STR forcing shift to zero
    load_ir = 1'b1; mem_data = 16'hA0B9;
    tick();
    expect_val("add_shift", S_SH, 16'h0003);
    expect_val("add_aluop", S_ALU, 16'h0000);
    expect_val("add_sx5", S_X5, 16'hFFF9);
    expect_val("add_sx8", S_X8, 16'hFFB9);
    check_all();
    mem_data = 16'h9818;
    tick();
    load_ir = 1'b0;
    expect_val("str_shift", S_SH, 16'h0000);
    expect_val("str_aluop", S_ALU, 16'h0003);
    check_all();

    // Illegal pc_sel sets a sticky error
    load_pc = 1'b1; pc_sel = 4'b0100; datapath_out = 16'h0005;
    tick();
    pc_sel = 4'b0110;
    tick();
    expect_val("bad_sel_pc", S_PC, 16'h0005);
    expect_val("bad_sel_err", S_ERR, 16'h0001);
    check_all();
    pc_sel = 4'b0001;
    tick();
    expect_val("legal_after_err", S_PC, 16'h0006);
    expect_val("err_sticky", S_ERR, 16'h0001);
    check_all();
    pc_sel = 4'b0000;
    tick();
    expect_val("zero_sel_pc", S_PC, 16'h0006);
    expect_val("zero_sel_err", S_ERR, 16'h0001);
    check_all();

    // Reset mid-operation clears everything
    reset = 1'b1; pc_sel = 4'b0001; load_ir = 1'b1; mem_data = 16'h1234;
    load_addr = 1'b1; datapath_out = 16'h0077;
    tick();
    idle();
    addr_sel = 1'b0;
    settle();
    expect_val("rst2_pc", S_PC, 16'h0000);
    expect_val("rst2_ir", S_IR, 16'h0000);
    expect_val("rst2_err", S_ERR, 16'h0000);
    expect_val("rst2_dar", S_MA, 16'h0000);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
